// File: rtl/mc_cpu_core.sv
// Multi-cycle core: IDLE -> LOAD -> EXEC -> WB, one instruction per 4 cycles, done pulses in WB.
// Optional `CPU_CARRY_CHAIN_EN turns op B into ADC (A + ry + flag_c); otherwise op B behaves as ADD.
module mc_cpu_core #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int RA = $clog2(NREGS),
  localparam int IW = 4 + 2 * RA
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [IW-1:0]    instr,
  input  logic [WIDTH-1:0] imm,
  output logic             done,
  output logic             busy,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  input  logic [RA-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, WB} state_t;

  state_t           state;
  logic [WIDTH-1:0] regs [NREGS];
  logic [3:0]       op;
  logic [RA-1:0]    rx, ry;
  logic [WIDTH-1:0] imm_q, a, g;
  logic             done_q, busy_q;

  logic [WIDTH-1:0] b, res;
  logic [WIDTH:0]   sum;
  logic             c_nxt, upd_flags, cin, wr_en;

  assign instr_ready = (state == IDLE) && !reset;
  assign done        = done_q;
  assign busy        = busy_q;
  assign dbg_data    = regs[dbg_addr];
  assign wr_en       = (op <= 4'h9) || (op == 4'hB);

`ifdef CPU_CARRY_CHAIN_EN
  assign cin = (op == 4'hB) ? flag_c : 1'b0;
`else
  assign cin = 1'b0;
`endif

  // ry is read here in EXEC; with rx==ry it still sees the old value since WB has not happened yet
  always_comb begin
    b         = (op == 4'h1) ? imm_q : regs[ry];
    res       = g;
    sum       = '0;
    c_nxt     = flag_c;
    upd_flags = 1'b1;
    case (op)
      4'h0, 4'h1: res = b;
      4'h2, 4'hB: begin
        sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        res   = sum[WIDTH-1:0];
        c_nxt = sum[WIDTH];
      end
      4'h3, 4'hA: begin
        sum   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        res   = sum[WIDTH-1:0];
        c_nxt = sum[WIDTH];
      end
      4'h4: begin res = a & b; c_nxt = 1'b0; end
      4'h5: begin res = a | b; c_nxt = 1'b0; end
      4'h6: begin res = a ^ b; c_nxt = 1'b0; end
      4'h7: begin res = ~b;    c_nxt = 1'b0; end
      4'h8: begin res = {a[WIDTH-2:0], 1'b0}; c_nxt = a[WIDTH-1]; end
      4'h9: begin res = {1'b0, a[WIDTH-1:1]}; c_nxt = a[0]; end
      default: upd_flags = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      op     <= '0;
      rx     <= '0;
      ry     <= '0;
      imm_q  <= '0;
      a      <= '0;
      g      <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (instr_valid) begin
          op     <= instr[IW-1 -: 4];
          rx     <= instr[2*RA-1 -: RA];
          ry     <= instr[RA-1:0];
          imm_q  <= imm;
          busy_q <= 1'b1;
          state  <= LOAD;
        end
        LOAD: begin
          a     <= regs[rx];
          state <= EXEC;
        end
        EXEC: begin
          g <= res;
          if (upd_flags) begin
            flag_c <= c_nxt;
            flag_z <= (res == '0);
            flag_n <= res[WIDTH-1];
          end
          done_q <= 1'b1;
          state  <= WB;
        end
        WB: begin
          if (wr_en) regs[rx] <= g;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_cpu_core.sv
// Bench for mc_cpu_core: directed instruction sequences against an instruction-level reference model.
module tb_mc_cpu_core;
  localparam int W  = 16;
  localparam int N  = 8;
  localparam int RA = 3;
  localparam int IW = 4 + 2 * RA;
  localparam longint MOD = 64'd1 << W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [IW-1:0] instr = '0;
  logic [W-1:0]  imm = '0;
  logic          done, busy, flag_c, flag_z, flag_n;
  logic [RA-1:0] dbg_addr = '0;
  logic [W-1:0]  dbg_data;

  mc_cpu_core #(.WIDTH(W), .NREGS(N)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .imm(imm), .done(done), .busy(busy), .flag_c(flag_c),
    .flag_z(flag_z), .flag_n(flag_n), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: architectural state updated per instruction, with the documented timing
  longint mregs [N];
  bit     mc, mz, mn;
  bit     mvalid = 0;
  bit     pend = 0;
  int     t_acc = 0;
  int     cyc = 0;
  longint nres;
  bit     nc, nflags, nwr;
  int     nrx;
  bit     ebusy, edone, eready;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_exec(input int op, input int rx, input int ry, input longint im);
    longint a, b, s;
    a = mregs[rx];
    b = (op == 1) ? im : mregs[ry];
    nres = 0; nc = mc; nflags = 1; nrx = rx;
    nwr = (op <= 9) || (op == 11);
    case (op)
      0, 1: nres = b;
      2, 11: begin
        s = a + b;
`ifdef CPU_CARRY_CHAIN_EN
        if (op == 11) s = s + longint'(mc);
`endif
        nres = s % MOD; nc = (s >= MOD);
      end
      3, 10: begin nres = (a - b + MOD) % MOD; nc = (a >= b); end
      4: begin nres = a & b; nc = 0; end
      5: begin nres = a | b; nc = 0; end
      6: begin nres = a ^ b; nc = 0; end
      7: begin nres = (MOD - 1) - b; nc = 0; end
      8: begin nres = (a * 2) % MOD; nc = (a >= MOD / 2); end
      9: begin nres = a / 2; nc = (a % 2 == 1); end
      default: nflags = 0;
    endcase
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      if (pend && cyc == t_acc + 3 && nflags) begin
        mc = nc; mz = (nres == 0); mn = (nres >= MOD / 2);
      end
      if (pend && cyc == t_acc + 4) begin
        if (nwr) mregs[nrx] = nres;
        pend = 0;
      end
      ebusy  = pend && cyc >= t_acc + 1 && cyc <= t_acc + 3;
      edone  = pend && cyc == t_acc + 3;
      eready = !reset && !ebusy;
      chk("busy", busy, ebusy);
      chk("done", done, edone);
      chk("instr_ready", instr_ready, eready);
      chk("flag_c", flag_c, mc);
      chk("flag_z", flag_z, mz);
      chk("flag_n", flag_n, mn);
      chk("dbg_data", dbg_data, mregs[dbg_addr]);
    end
    if (reset) begin
      for (int i = 0; i < N; i++) mregs[i] = 0;
      mc = 0; mz = 0; mn = 0; pend = 0; mvalid = 1;
    end else if (mvalid && instr_valid && !pend) begin
      model_exec(int'(instr[IW-1 -: 4]), int'(instr[2*RA-1 -: RA]), int'(instr[RA-1:0]), longint'(imm));
      pend = 1;
      t_acc = cyc;
    end
  end

  task automatic issue(input int op, input int rx, input int ry, input longint im);
    bit acc;
    int lat;
    @(posedge clk); #1;
    instr = {4'(op), 3'(rx), 3'(ry)};
    imm = 16'(im);
    instr_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_ready) begin acc = 1; break; end
    end
    if (!acc) begin
      chk("accept_timeout", 0, 1);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    lat = 0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (done) begin lat = j + 1; break; end
    end
    chk("done_latency", lat, 4);
    @(posedge clk); #1;
  endtask

  task automatic rd(input int r, input longint exp, input string name);
    dbg_addr = 3'(r);
    @(negedge clk);
    chk(name, dbg_data, exp);
  endtask

  int na, nd;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {flag_c, flag_z, flag_n}, 0);
    for (int i = 0; i < N; i++) rd(i, 0, "rst_reg");

    // ADD overflow to zero
    issue(1, 1, 0, 'h00FF);
    issue(1, 2, 0, 'hFF01);
    issue(2, 1, 2, 0);
    chk("add_c", flag_c, 1);
    chk("add_z", flag_z, 1);
    chk("add_n", flag_n, 0);
    rd(1, 'h0000, "add_r1");

    // SUB with borrow, then CMP
    issue(1, 3, 0, 5);
    issue(1, 4, 0, 7);
    issue(3, 3, 4, 0);
    chk("sub_c", flag_c, 0);
    chk("sub_n", flag_n, 1);
    rd(3, 'hFFFE, "sub_r3");
    issue(10, 4, 3, 0);
    chk("cmp_c", flag_c, 0);
    chk("cmp_z", flag_z, 0);
    rd(4, 7, "cmp_r4");

    // valid held high while busy
    @(posedge clk); #1;
    instr = {4'd2, 3'd1, 3'd2};
    instr_valid = 1'b1;
    na = 0; nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (instr_valid && instr_ready) na++;
      if (done) nd++;
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("hold_accepts", na, 3);
    chk("hold_dones", nd, 3);
    rd(1, 'hFD03, "hold_r1");

    // logic and shift ops
    issue(1, 6, 0, 'hA5C3);
    issue(1, 7, 0, 'h0F0F);
    issue(4, 6, 7, 0);
    rd(6, 'h0503, "and_r6");
    issue(5, 6, 7, 0);
    issue(6, 6, 7, 0);
    chk("xor_z", flag_z, 1);
    issue(7, 6, 7, 0);
    rd(6, 'hF0F0, "not_r6");
    issue(1, 0, 0, 'h8001);
    issue(8, 0, 0, 0);
    chk("shl_c", flag_c, 1);
    rd(0, 'h0002, "shl_r0");
    issue(1, 0, 0, 'h8001);
    issue(9, 0, 0, 0);
    rd(0, 'h4000, "shr_r0");
    issue(0, 6, 0, 0);
    issue(12, 6, 1, 0);
    rd(6, 'h4000, "nop_r6");

    // reset during EXEC aborts the instruction
    issue(1, 5, 0, 3);
    @(posedge clk); #1;
    instr = {4'd2, 3'd5, 3'd5};
    instr_valid = 1'b1;
    @(negedge clk);
    chk("abort_accept", instr_ready, 1);
    @(posedge clk); #1 instr_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    nd = 0;
    @(negedge clk);
    chk("abort_ready", instr_ready, 1);
    if (done) nd++;
    repeat (3) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    rd(5, 0, "abort_r5");

    // carry chain
    issue(1, 1, 0, 'hFFFF);
    issue(1, 2, 0, 1);
    issue(2, 1, 2, 0);
    chk("chain_c", flag_c, 1);
    issue(1, 3, 0, 0);
    issue(1, 4, 0, 0);
    issue(11, 3, 4, 0);
`ifdef CPU_CARRY_CHAIN_EN
    rd(3, 1, "adc_r3");
`else
    rd(3, 0, "adc_r3");
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
